// File: rtl/imm_pkg.sv
// Shared types for the immediate-generation pipeline: format selects and the
// buffered entry carried through the main/skid registers.
package imm_pkg;

    typedef enum logic [2:0] {
        SEL_I = 3'd0,
        SEL_S = 3'd1,
        SEL_B = 3'd2,
        SEL_J = 3'd3,
        SEL_U = 3'd4,
        SEL_Z = 3'd5
    } imm_sel_e;

    // Every RV immediate fits in 32 bits once sign-extended from inst[31];
    // widening to XLEN happens at the output, so the entry stays XLEN-agnostic.
    typedef struct packed {
        logic [31:0] imm;
        logic        sel_err;
    } imm_entry_t;

endpackage

// File: rtl/imm_decode.sv
// Purely combinational RISC-V immediate decoder producing a canonical 32-bit
// sign-extended immediate plus an illegal-select flag.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit EN_ZIMM = 1'b1
) (
    input  logic [24:0] inst_i,
    input  logic [2:0]  imm_sel_i,
    output imm_entry_t  entry_o
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_decode: XLEN must be 32 or 64");
        end
    endgenerate

    // Re-index so bit positions read exactly like the instruction encoding.
    logic [31:7] ins;
    assign ins = inst_i;

    always_comb begin
        entry_o = '0;
        case (imm_sel_e'(imm_sel_i))
            SEL_I: entry_o.imm = {{20{ins[31]}}, ins[31:20]};
            SEL_S: entry_o.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            SEL_B: entry_o.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            SEL_J: entry_o.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            SEL_U: entry_o.imm = {ins[31:12], 12'b0};
            SEL_Z: begin
                if (EN_ZIMM) entry_o.imm = {27'b0, ins[19:15]};
                else         entry_o.sel_err = 1'b1;
            end
            default: entry_o.sel_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a registered output stage and one-entry skid buffer
// so in_ready_o never depends combinationally on out_ready_i.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit EN_ZIMM = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [24:0]     inst_i,
    input  logic [2:0]      imm_sel_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic            sel_err_o
);

    imm_entry_t dec;
    imm_entry_t main_q, skid_q;
    logic       main_vld, skid_vld;
    logic       in_acc, out_xfer;

    imm_decode #(
        .XLEN    (XLEN),
        .EN_ZIMM (EN_ZIMM)
    ) u_decode (
        .inst_i    (inst_i),
        .imm_sel_i (imm_sel_i),
        .entry_o   (dec)
    );

    assign in_ready_o = ~skid_vld;
    assign in_acc     = in_valid_i & in_ready_o;
    assign out_xfer   = main_vld & out_ready_i;

    // Skid can only fill while main is stalled, and input is refused while
    // skid is full, so an accept never coincides with a skid drain.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (flush_i) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (out_xfer) begin
            if (skid_vld) begin
                main_q   <= skid_q;
                skid_vld <= 1'b0;
            end else if (in_acc) begin
                main_q   <= dec;
            end else begin
                main_vld <= 1'b0;
            end
        end else if (in_acc) begin
            if (main_vld) begin
                skid_q   <= dec;
                skid_vld <= 1'b1;
            end else begin
                main_q   <= dec;
                main_vld <= 1'b1;
            end
        end
    end

    assign out_valid_o = main_vld;
    assign imm_o       = XLEN'(signed'(main_q.imm));
    assign sel_err_o   = main_q.sel_err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances share stimulus and are
// compared every cycle against a queue-based reference model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] inst;
    logic [2:0]  sel;

    logic        rdy32, ov32, err32, rdy64, ov64, err64;
    logic [31:0] imm32;
    logic [63:0] imm64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .EN_ZIMM(1'b1)) u32 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy32),
        .inst_i(inst[31:7]), .imm_sel_i(sel),
        .out_valid_o(ov32), .out_ready_i(out_ready),
        .imm_o(imm32), .sel_err_o(err32)
    );

    imm_gen_pipe #(.XLEN(64), .EN_ZIMM(1'b1)) u64 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy64),
        .inst_i(inst[31:7]), .imm_sel_i(sel),
        .out_valid_o(ov64), .out_ready_i(out_ready),
        .imm_o(imm64), .sel_err_o(err64)
    );

    typedef struct {
        logic [63:0] imm;
        bit          err;
    } ment_t;

    ment_t q[$];

    // Reference decode from field arithmetic on the full 32-bit word.
    function automatic ment_t ref_dec(input logic [31:0] x, input int s);
        ment_t  m;
        longint sx, t;
        sx = longint'(signed'(x));
        m.err = 1'b0;
        m.imm = '0;
        case (s)
            0: begin t = sx >>> 20; m.imm = t; end
            1: begin t = sx >>> 25; m.imm = (t << 5) | ((x >> 7) & 31); end
            2: begin
                t = sx >>> 31;
                m.imm = (t << 12) | (((x >> 7) & 1) << 11) | (((x >> 25) & 63) << 5)
                      | (((x >> 8) & 15) << 1);
            end
            3: begin
                t = sx >>> 31;
                m.imm = (t << 20) | (((x >> 12) & 255) << 12) | (((x >> 20) & 1) << 11)
                      | (((x >> 21) & 1023) << 1);
            end
            4: begin t = sx >>> 12; m.imm = t << 12; end
            5: m.imm = 64'((x >> 15) & 31);
            default: m.err = 1'b1;
        endcase
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Model update: single FIFO of depth two with flush/reset clearing it.
    always @(posedge clk) begin
        bit xo, ai;
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            xo = (q.size() > 0) && out_ready;
            ai = in_valid && (q.size() < 2);
            if (xo) void'(q.pop_front());
            if (ai) q.push_back(ref_dec(inst, int'(sel)));
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("in_ready32", 64'(rdy32), 64'(q.size() < 2));
        chk("in_ready64", 64'(rdy64), 64'(q.size() < 2));
        chk("out_valid32", 64'(ov32), 64'(q.size() > 0));
        chk("out_valid64", 64'(ov64), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("imm32", 64'(imm32), 64'(q[0].imm[31:0]));
            chk("imm64", imm64, q[0].imm);
            chk("sel_err32", 64'(err32), 64'(q[0].err));
            chk("sel_err64", 64'(err64), 64'(q[0].err));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] x, input logic [2:0] s);
        in_valid = v;
        inst     = x;
        sel      = s;
    endtask

    ment_t exp_e[3];
    logic [31:0] bp_inst[3];

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0, 3'd0);
        step(); step();
        chk("rst_out_valid", 64'(ov32), 64'd0);
        chk("rst_imm64", imm64, 64'd0);
        chk("rst_sel_err", 64'(err32), 64'd0);
        chk("rst_in_ready", 64'(rdy64), 64'd1);
        rst_n = 1'b1;

        // Directed format cases with literal expectations.
        drive(1'b1, 32'hFFF00093, 3'd0); step();
        chk("i_valid", 64'(ov32), 64'd1);
        chk("i_imm32", 64'(imm32), 64'hFFFF_FFFF);
        chk("i_err", 64'(err32), 64'd0);
        drive(1'b1, 32'hFE000EE3, 3'd2); step();
        chk("b_imm32", 64'(imm32), 64'hFFFF_FFFC);
        drive(1'b1, 32'h800000B7, 3'd4); step();
        chk("u_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("u_imm32", 64'(imm32), 64'h8000_0000);
        drive(1'b1, 32'h000FD073, 3'd5); step();
        chk("z_imm64", imm64, 64'h1F);
        drive(1'b0, 32'h0, 3'd0); step();
        chk("drain_valid", 64'(ov32), 64'd0);

        // Backpressure: three back-to-back offers into a stalled output.
        for (int i = 0; i < 3; i++) begin
            bp_inst[i] = $urandom;
            exp_e[i]   = ref_dec(bp_inst[i], i);
        end
        out_ready = 1'b0;
        drive(1'b1, bp_inst[0], 3'd0); step();
        chk("bp_rdy_after1", 64'(rdy32), 64'd1);
        drive(1'b1, bp_inst[1], 3'd1); step();
        chk("bp_rdy_after2", 64'(rdy32), 64'd0);
        drive(1'b1, bp_inst[2], 3'd2); step();
        chk("bp_hold_a", imm64, exp_e[0].imm);
        step();
        chk("bp_hold_b", imm64, exp_e[0].imm);
        chk("bp_hold_valid", 64'(ov64), 64'd1);
        out_ready = 1'b1; step();
        chk("bp_out1", imm64, exp_e[1].imm);
        chk("bp_rdy_back", 64'(rdy64), 64'd1);
        step();
        chk("bp_out2", imm64, exp_e[2].imm);
        drive(1'b0, 32'h0, 3'd0); step();
        chk("bp_empty", 64'(ov64), 64'd0);

        // Flush with both entries full, then an illegal select.
        out_ready = 1'b0;
        drive(1'b1, $urandom, 3'd0); step();
        drive(1'b1, $urandom, 3'd3); step();
        flush = 1'b1;
        drive(1'b1, $urandom, 3'd1); step();
        flush = 1'b0;
        chk("fl_valid", 64'(ov32), 64'd0);
        chk("fl_rdy", 64'(rdy32), 64'd1);
        out_ready = 1'b1;
        drive(1'b1, 32'hFFFF_FFFF, 3'd7); step();
        chk("ill_imm64", imm64, 64'd0);
        chk("ill_err", 64'(err64), 64'd1);
        drive(1'b0, 32'h0, 3'd0); step();

        // Reset while stalled with both entries full.
        out_ready = 1'b0;
        drive(1'b1, $urandom, 3'd4); step();
        drive(1'b1, $urandom, 3'd4); step();
        rst_n = 1'b0; out_ready = 1'b1;
        drive(1'b1, $urandom, 3'd0); step();
        chk("rs_valid", 64'(ov64), 64'd0);
        chk("rs_imm64", imm64, 64'd0);
        chk("rs_imm32", 64'(imm32), 64'd0);
        chk("rs_rdy", 64'(rdy64), 64'd1);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 3'd0); step();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1; flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the immediate output width; only 32 and 64 are legal, and any other value SHALL fail elaboration.
REQ-002 Parameter EN_ZIMM, default 1, SHALL enable Z-type (CSR zimm) decode; when 0, Z-type is treated as an illegal select.
REQ-003 Port clk_i, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port rst_ni, input, 1, is the reset: synchronous, active-low.
REQ-005 Port flush_i, input, 1, discards all buffered entries.
REQ-006 Port in_valid_i, input, 1, marks the upstream instruction as valid.
REQ-007 Port in_ready_o, output, 1, indicates the block accepts an input this cycle.
REQ-008 Port inst_i, input, 25, carries instruction bits [31:7].
REQ-009 Port imm_sel_i, input, 3, selects the immediate format.
REQ-010 Port out_valid_o, output, 1, marks the immediate as valid.
REQ-011 Port out_ready_i, input, 1, indicates downstream acceptance.
REQ-012 Port imm_o, output, XLEN, carries the generated immediate.
REQ-013 Port sel_err_o, output, 1, flags an illegal select for the current output entry.

Function
REQ-014 Select encodings SHALL be I=0, S=1, B=2, J=3, U=4, Z=5; codes 6 and 7 are illegal.
REQ-015 I-type SHALL produce sext(inst[31:20]).
REQ-016 S-type SHALL produce sext({inst[31:25], inst[11:7]}).
REQ-017 B-type SHALL produce sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
REQ-018 J-type SHALL produce sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
REQ-019 U-type SHALL produce sext({inst[31:12], 12'b0}) to XLEN; sign extension applies when XLEN=64.
REQ-020 Z-type SHALL produce zext(inst[19:15]).
REQ-021 All sign extension SHALL replicate inst[31] up to XLEN bits.
REQ-022 An illegal select SHALL produce imm=0 and sel_err=1, stored alongside the entry.
REQ-023 Handshakes SHALL use valid/ready; a transfer occurs when valid and ready are both high at a rising edge.
REQ-024 Storage SHALL be a main output register plus a one-entry skid register, each holding {imm, sel_err, valid}.
REQ-025 Decode SHALL be combinational into the registers; latency is 1 cycle from input handshake to out_valid_o, with no bubble at full throughput.
REQ-026 in_ready_o SHALL equal NOT skid_valid; it is registered-derived and has no combinational path from out_ready_i.
REQ-027 If the input is accepted while the main register is stalled (valid and NOT out_ready), the entry SHALL go to the skid register.
REQ-028 On an output transfer with skid valid, the skid entry SHALL move to main and skid SHALL clear.
REQ-029 On an output transfer with skid empty, main SHALL load the current input if it is accepted, else clear its valid.
REQ-030 Simultaneous input accept and output transfer with skid empty SHALL load main directly.
REQ-031 Ordering SHALL be strict FIFO; no entry is dropped or duplicated.
REQ-032 flush_i=1 SHALL clear both valids next cycle and ignore any input in that cycle; the in_valid handshake is not counted.
REQ-033 The flush SHALL take priority over all handshakes.
REQ-034 imm_o and sel_err_o SHALL be held stable while out_valid_o=1 and out_ready_i=0.

Reset
REQ-035 With rst_ni=0 at a rising edge, out_valid_o=0, skid_valid=0, imm_o=0 and sel_err_o=0 SHALL hold next cycle.
REQ-036 in_ready_o SHALL be 1 after reset.
REQ-037 Reset SHALL take priority over flush_i and over an in-flight handshake; entries are discarded.

Structure
REQ-038 Package imm_pkg SHALL hold the imm_sel_e enum (I,S,B,J,U,Z) and the entry struct {imm, sel_err}.
REQ-039 Sub-module imm_decode SHALL be purely combinational and parametrised by XLEN and EN_ZIMM, instantiated once ahead of the registers.

Verification
REQ-040 Bench SHALL cover the I-type case: XLEN=32, inst=0xFFF00093, sel=I, out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, sel_err=0.
REQ-041 Bench SHALL cover the B-type case: inst=0xFE000EE3, sel=B -> imm=0xFFFFFFFC.
REQ-042 Bench SHALL cover U-type sign extension at XLEN=64: inst=0x800000B7, sel=U -> imm=0xFFFFFFFF80000000; and inst=0x000FD073, sel=Z -> imm=0x1F.
REQ-043 Bench SHALL cover backpressure: send 3 back-to-back entries with out_ready=0 -> in_ready drops after the 2nd; with out_ready then 1, the outputs emerge in order with imm held stable while stalled.
REQ-044 Bench SHALL cover flush and illegal select: flush with both entries full -> next cycle out_valid=0 and in_ready=1; then sel=7 -> imm=0, sel_err=1.
REQ-045 Bench SHALL cover reset mid-stall: rst_ni=0 with both entries full -> next cycle out_valid=0, imm_o=0, in_ready=1.
